// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder family: FSM state
// encoding and default timing constants for the 100 MHz board clock.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    // 1 s long-press threshold and 250 ms repeat period at 100 MHz.
    localparam int DEF_LONG_CYCLES   = 100_000_000;
    localparam int DEF_REPEAT_CYCLES = 25_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Event bus between one debounced switch and its event consumers.
// The master drives the switch level; the slave produces the events.
interface button_event_decoder_if;
    logic CLEAN;
    logic PRESS;
    logic RELEASE;
    logic SHORT;
    logic LONG;
    logic REPEAT;
    logic HELD;

    modport master (
        output CLEAN,
        input  PRESS, RELEASE, SHORT, LONG, REPEAT, HELD
    );

    modport slave (
        input  CLEAN,
        output PRESS, RELEASE, SHORT, LONG, REPEAT, HELD
    );
endinterface

// File: rtl/button_event_decoder_level_edge_detect.sv
// Registers the previous level sample and flags rising/falling edges
// combinationally against the current sample.
module level_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);
    logic clean_q;

    // Previous-sample register; resets low so a level held high through
    // reset is reported as a rising edge on the first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= 1'b0;
        end else begin
            clean_q <= level_i;
        end
    end

    assign rise_o = level_i & ~clean_q;
    assign fall_o = ~level_i & clean_q;
endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into one-clock press / release / short /
// long / repeat events plus a registered held level. All outputs come
// straight from registers in the FSM below.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,   // must be >= 2
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES  // 0 disables repeat
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_event_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  =
        (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
    localparam bit REP_EN = (REPEAT_CYCLES != 0);

    logic rise;
    logic fall;

    level_edge_detect u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (bus.CLEAN),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;

    // Event FSM with registered outputs; release is tested first in each
    // held state so it wins over a coincident LONG or REPEAT. While held,
    // clean_q is 1, so fall is exactly "CLEAN sampled low".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PRESSED;
                        cnt_q   <= CNT_W'(1);
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= LONG_HELD;
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (!REP_EN) begin
                        cnt_q <= '0;
                    end else if (cnt_q == REP_LAST) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PRESS   = press_q;
    assign bus.RELEASE = release_q;
    assign bus.SHORT   = short_q;
    assign bus.LONG    = long_q;
    assign bus.REPEAT  = repeat_q;
    assign bus.HELD    = held_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8; one instance
// with REPEAT_CYCLES=4 and one with repeat disabled.
// Output vectors are {PRESS, RELEASE, SHORT, LONG, REPEAT, HELD}.
module tb_button_event_decoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_long;
    int   n_rep;

    button_event_decoder_if a_if ();
    button_event_decoder_if b_if ();

    button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_HELD = 6'b000001;
    localparam logic [5:0] O_PRS  = 6'b100001;
    localparam logic [5:0] O_RLS  = 6'b011000;
    localparam logic [5:0] O_RL   = 6'b010000;
    localparam logic [5:0] O_LONG = 6'b000101;
    localparam logic [5:0] O_REP  = 6'b000011;

    function automatic logic [5:0] outs_a();
        return {a_if.PRESS, a_if.RELEASE, a_if.SHORT, a_if.LONG, a_if.REPEAT, a_if.HELD};
    endfunction

    function automatic logic [5:0] outs_b();
        return {b_if.PRESS, b_if.RELEASE, b_if.SHORT, b_if.LONG, b_if.REPEAT, b_if.HELD};
    endfunction

    // Drive both CLEAN inputs, take one edge, sample 1 time unit later.
    task automatic cyc(input logic ca, input logic cb);
        a_if.CLEAN = ca;
        b_if.CLEAN = cb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        logic [5:0] e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_if.CLEAN = 1'b0;
        b_if.CLEAN = 1'b0;
        #1;
        chk("reset_a", outs_a(), O_NONE);
        chk("reset_b", outs_b(), O_NONE);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(0, 0);
        chk("idle_a", outs_a(), O_NONE);

        // Short press: 3 high samples
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0);
            chk($sformatf("short_e%0d", i), outs_a(), (i == 1) ? O_PRS : O_HELD);
        end
        cyc(0, 0);
        chk("short_release", outs_a(), O_RLS);
        cyc(0, 0);
        chk("short_after", outs_a(), O_NONE);
        $display("txn short_press done checks=%0d", checks);

        // Long press with repeats: 20 high samples
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 0);
            if (i == 1)                            e = O_PRS;
            else if (i == 8)                       e = O_LONG;
            else if (i == 12 || i == 16 || i == 20) e = O_REP;
            else                                   e = O_HELD;
            chk($sformatf("long_e%0d", i), outs_a(), e);
        end
        cyc(0, 0);
        chk("long_release", outs_a(), O_RL);
        cyc(0, 0);
        $display("txn long_press_repeat done checks=%0d", checks);

        // Boundary: 7 highs -> short, no LONG
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0);
            chk($sformatf("b7_e%0d", i), outs_a(), (i == 1) ? O_PRS : O_HELD);
        end
        cyc(0, 0);
        chk("b7_release", outs_a(), O_RLS);
        cyc(0, 0);
        $display("txn boundary7 done checks=%0d", checks);

        // Boundary: 8 highs -> LONG then plain release
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0);
            chk($sformatf("b8_e%0d", i), outs_a(), (i == 1) ? O_PRS : (i == 8) ? O_LONG : O_HELD);
        end
        cyc(0, 0);
        chk("b8_release", outs_a(), O_RL);
        cyc(0, 0);
        $display("txn boundary8 done checks=%0d", checks);

        // Release on a REPEAT edge (repeat would fire on sample 12)
        for (int i = 1; i <= 11; i++) cyc(1, 0);
        cyc(0, 0);
        chk("rep_edge_release", outs_a(), O_RL);
        cyc(0, 0);
        $display("txn release_on_repeat_edge done checks=%0d", checks);

        // Repeat disabled: 30 highs on the second instance
        n_long = 0;
        n_rep  = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(0, 1);
            if (b_if.LONG)   n_long++;
            if (b_if.REPEAT) n_rep++;
            if (i == 1 || i == 8 || i == 9 || i == 13 || i == 30)
                chk($sformatf("norep_e%0d", i), outs_b(), (i == 1) ? O_PRS : (i == 8) ? O_LONG : O_HELD);
        end
        chk_int("norep_long_count", n_long, 1);
        chk_int("norep_repeat_count", n_rep, 0);
        cyc(0, 0);
        chk("norep_release", outs_b(), O_RL);
        cyc(0, 0);
        $display("txn repeat_disabled done checks=%0d", checks);

        // Reset mid-press, then restart with CLEAN high
        for (int i = 1; i <= 4; i++) cyc(1, 0);
        chk("mid_held", outs_a(), O_HELD);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_async", outs_a(), O_NONE);
        @(posedge clk);
        #1;
        chk("mid_reset_hold", outs_a(), O_NONE);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0);
            chk($sformatf("rst_e%0d", i), outs_a(), (i == 1) ? O_PRS : (i == 8) ? O_LONG : O_HELD);
        end
        cyc(0, 0);
        chk("rst_release", outs_a(), O_RL);
        cyc(0, 0);
        $display("txn reset_mid_press done checks=%0d", checks);

        // Back-to-back minimum presses
        cyc(1, 0);
        chk("b2b_press1", outs_a(), O_PRS);
        cyc(0, 0);
        chk("b2b_release1", outs_a(), O_RLS);
        cyc(1, 0);
        chk("b2b_press2", outs_a(), O_PRS);
        cyc(0, 0);
        chk("b2b_release2", outs_a(), O_RLS);
        cyc(0, 0);
        chk("b2b_idle", outs_a(), O_NONE);
        $display("txn back_to_back done checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the debounced switch level produced by the switch debouncer into single-cycle button events: press, release, short press, long press, and auto-repeat while held. It sits directly downstream of the debouncer, one instance per button, and feeds the lab's control logic with one-clock pulses. Its input is already synchronous to `clk`, so the block has no synchroniser.

## Interface
- `LONG_CYCLES`, default 100_000_000: consecutive high samples, counting the press sample, that qualify as a long press. Must be ≥ 2.
- `REPEAT_CYCLES`, default 25_000_000: period of `REPEAT` pulses after `LONG`. A value of 0 disables repeat.
- `CNT_W`, localparam: `$clog2(max(LONG_CYCLES, REPEAT_CYCLES)) + 1`.
- `clk` in 1: single clock. All logic is on `posedge clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `CLEAN` in 1: debounced switch level, where 1 means pressed.
- `PRESS` out 1: one-cycle pulse on the press edge.
- `RELEASE` out 1: one-cycle pulse on the release edge.
- `SHORT` out 1: one-cycle pulse on release if `LONG` never fired during this press.
- `LONG` out 1: one-cycle pulse, fired exactly once per press.
- `REPEAT` out 1: one-cycle pulse every `REPEAT_CYCLES` while held after `LONG`.
- `HELD` out 1: registered level, 1 from the `PRESS` cycle through the cycle before `RELEASE`.

## Operation
- **Internal registers:** `clean_q` (previous sample), state, `cnt[CNT_W-1:0]`.
- **States:** `IDLE`, `PRESSED`, `LONG_HELD`.
- **IDLE:**
  - If `CLEAN=1` and `clean_q=0`, go to `PRESSED`, set `cnt=1`, assert `PRESS` and `HELD`.
- **PRESSED:**
  - If `CLEAN=0`, go to `IDLE`, assert `RELEASE` and `SHORT`, clear `HELD`.
  - Else if `cnt == LONG_CYCLES-1`, go to `LONG_HELD`, assert `LONG`, set `cnt=0`.
  - Else `cnt` increments.
- **LONG_HELD:**
  - If `CLEAN=0`, go to `IDLE`, assert `RELEASE` only (no `SHORT`), clear `HELD`.
  - Else if `REPEAT_CYCLES != 0` and `cnt == REPEAT_CYCLES-1`, assert `REPEAT` and set `cnt=0`.
  - Else `cnt` increments.
  - If `REPEAT_CYCLES == 0`, `cnt` holds at 0.
- **Mutual exclusion:** at most one of `PRESS`, `LONG`, `REPEAT`, `RELEASE` is high in any cycle. `SHORT` is high only together with `RELEASE`.
- **Counter range:** `cnt` never wraps; it is always reloaded before reaching its width limit.

## Timing
- **Outputs:** all registered. An event is visible in the cycle after the `posedge` at which the triggering `CLEAN` sample is taken.
- **Press at edge e0:** `PRESS` is high in cycle e0+1.
- **Long press:** with `CLEAN` held, `LONG` is high after edge e0+`LONG_CYCLES`-1.
- **Repeat:** the k-th `REPEAT` is high after edge e0+`LONG_CYCLES`-1+k·`REPEAT_CYCLES`.
- **Release sampled at edge r:** `RELEASE` (and `SHORT` if applicable) is high in cycle r+1, and `HELD` falls in cycle r+1.
- **Release on a LONG/REPEAT edge:** release has priority. A low sample at the edge where `LONG` would fire yields `SHORT`+`RELEASE` and no `LONG`. A low sample at the edge where `REPEAT` would fire yields `RELEASE` only.
- **Minimum press:** a 1-cycle high on `CLEAN` gives `PRESS` at e0+1, then `RELEASE`+`SHORT` at e0+2.
- **Re-press:** a press is accepted in the cycle immediately after a release, so back-to-back events are allowed.
- **Reset:** while `rst_n=0`, all outputs are 0, `clean_q=0`, state is `IDLE`, and `cnt=0`. Reset takes effect immediately, asynchronously, including mid-press; no `RELEASE` is emitted for an aborted press.
- **Exit from reset:** if `CLEAN=1` at the first edge after `rst_n` deasserts, a press is reported, because `clean_q` resets to 0.

## Structure
- **Shared package** `button_pkg`:
  - state typedef (`IDLE`, `PRESSED`, `LONG_HELD`; 2-bit encoding);
  - default timing constants for the 100 MHz board clock.
- **Sub-module** `level_edge_detect`:
  - contains `clean_q` and produces combinational `rise`/`fall` strobes;
  - reused by other switch consumers.
- **Outputs:** all event outputs are driven from a single registered output stage in this module.

## Test plan
All scenarios use `LONG_CYCLES=8` and `REPEAT_CYCLES=4`.
- **Short press:** `CLEAN` high for 3 edges -> `PRESS` at e0+1, `HELD` high for 3 cycles, then `RELEASE`+`SHORT` at e0+4; no `LONG`.
- **Long press with repeats:** `CLEAN` high for 20 edges -> `PRESS` at e0+1, `LONG` at e0+8, `REPEAT` at e0+12, e0+16 and e0+20, `RELEASE` (no `SHORT`) at e0+21.
- **Boundary release:** `CLEAN` high for exactly 7 edges -> `RELEASE`+`SHORT` at e0+8, `LONG` never asserted. Holding for 8 edges instead gives `LONG` at e0+8 and `RELEASE` without `SHORT` at e0+9.
- **Repeat disabled:** with `REPEAT_CYCLES=0`, hold 30 edges -> exactly one `LONG`, zero `REPEAT`s, then `RELEASE`.
- **Reset mid-press:** pull `rst_n` low at e0+5 -> all outputs 0 immediately. Release reset with `CLEAN=1` -> `PRESS` one cycle after the first edge, and the counter restarts from 1.
- **Back-to-back presses:** 1-high/1-low/1-high pattern on `CLEAN` -> `PRESS`, `RELEASE`+`SHORT`, `PRESS` on consecutive cycles, with no missed or merged events.
